// File: rtl/ula_pkg.sv
// Shared definitions for the 8-bit ULA and the command sequencer that feeds it.
//
// Contents:
//   DATA_W / RES_W / OP_W  default operand, result and opcode widths
//   OP_*                   opcode values presented on the ULA Seletor input
//   seq_state_e            sequencer FSM state encoding
package ula_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned RES_W  = 16;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV  = 4'd3;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd4;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd5;
    localparam logic [OP_W-1:0] OP_ROL  = 4'd6;
    localparam logic [OP_W-1:0] OP_ROR  = 4'd7;
    localparam logic [OP_W-1:0] OP_AND  = 4'd8;
    localparam logic [OP_W-1:0] OP_OR   = 4'd9;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd10;
    localparam logic [OP_W-1:0] OP_NOR  = 4'd11;
    localparam logic [OP_W-1:0] OP_NAND = 4'd12;
    localparam logic [OP_W-1:0] OP_XNOR = 4'd13;
    localparam logic [OP_W-1:0] OP_GT   = 4'd14;
    localparam logic [OP_W-1:0] OP_EQ   = 4'd15;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } seq_state_e;

endpackage

// File: rtl/ula_sequencer.sv
// Command sequencer in front of the 8-bit ULA.
//
// Takes one (op, A, B) command at a time over a valid/ready handshake, drives the ULA's
// registered inputs, waits out the ULA's output register, captures S together with zero and
// divide-by-zero flags, and offers the result over a valid/ready handshake. Completed
// hand-offs are counted in op_count.
//
// Ports:
//   clock, reset                       rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready                command handshake (cmd_ready high only when idle)
//   cmd_op, cmd_a, cmd_b, cmd_acc      command payload
//   alu_sel, alu_a, alu_b              registered drive to the ULA inputs
//   alu_s                              ULA result, valid one clock after the ULA samples
//   res_valid/res_ready                result handshake
//   res_data, res_zero, res_err        captured result and flags
//   busy                               high whenever an operation is in flight
//   op_count                           number of results handed off (wrapping)
//
// Build option: ULA_SEQ_ACC_EN -- when defined, cmd_acc=1 at accept feeds the low DATA_W bits
// of the last result into alu_a instead of cmd_a. When undefined, cmd_acc is ignored.
module ula_sequencer
    import ula_pkg::*;
#(
    parameter int unsigned DATA_W = ula_pkg::DATA_W,
    parameter int unsigned RES_W  = ula_pkg::RES_W,
    parameter int unsigned OP_W   = ula_pkg::OP_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_acc,

    output logic [OP_W-1:0]   alu_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [RES_W-1:0]  alu_s,

    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              res_zero,
    output logic              res_err,

    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    if (RES_W != 2 * DATA_W) begin : g_width_check
        $error("ula_sequencer: RES_W must equal 2*DATA_W");
    end

    seq_state_e state_q, state_d;

    logic              div0_q, div0_d;
    logic [OP_W-1:0]   sel_d;
    logic [DATA_W-1:0] a_d, b_d;
    logic [RES_W-1:0]  res_data_d;
    logic              res_valid_d, res_zero_d, res_err_d;
    logic [CNT_W-1:0]  op_count_d;
    logic [DATA_W-1:0] a_src;

`ifdef ULA_SEQ_ACC_EN
    // res_data still holds the last completed result whenever a command can be accepted.
    assign a_src = cmd_acc ? res_data[DATA_W-1:0] : cmd_a;
`else
    logic acc_unused;
    assign acc_unused = cmd_acc;
    assign a_src      = cmd_a;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_valid) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  state_d = StDone;
            StDone:  if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic: handshake signals plus next values of the registered outputs
    always_comb begin
        cmd_ready   = (state_q == StIdle);
        busy        = (state_q != StIdle);
        sel_d       = alu_sel;
        a_d         = alu_a;
        b_d         = alu_b;
        div0_d      = div0_q;
        res_data_d  = res_data;
        res_valid_d = res_valid;
        res_zero_d  = res_zero;
        res_err_d   = res_err;
        op_count_d  = op_count;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    sel_d  = cmd_op;
                    a_d    = a_src;
                    b_d    = cmd_b;
                    div0_d = (cmd_op == OP_W'(OP_DIV)) && (cmd_b == '0);
                end
            end
            StWait: begin
                // A divide by zero discards whatever the ULA produced.
                res_data_d  = div0_q ? '0 : alu_s;
                res_zero_d  = div0_q || (alu_s == '0);
                res_err_d   = div0_q;
                res_valid_d = 1'b1;
            end
            StDone: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            alu_sel   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            div0_q    <= 1'b0;
            res_data  <= '0;
            res_valid <= 1'b0;
            res_zero  <= 1'b0;
            res_err   <= 1'b0;
            op_count  <= '0;
        end else begin
            alu_sel   <= sel_d;
            alu_a     <= a_d;
            alu_b     <= b_d;
            div0_q    <= div0_d;
            res_data  <= res_data_d;
            res_valid <= res_valid_d;
            res_zero  <= res_zero_d;
            res_err   <= res_err_d;
            op_count  <= op_count_d;
        end
    end

endmodule

// File: doc/ula_sequencer.md
Name: ula_sequencer

Overview:
Upstream command stage for the 8-bit ULA.
- Accepts operation commands (op, A, B) over a valid/ready handshake.
- Drives the ULA's registered-input ports, waits out the ULA's one-clock output register, captures S, adds status flags, and presents the result over a valid/ready handshake.
- Serialises one operation at a time and counts completed operations.

Parameters:
DATA_W, 8, operand width (ULA A/B width)
RES_W, 16, result width; must equal 2*DATA_W
OP_W, 4, opcode width (ULA Seletor width)
CNT_W, 16, width of completed-operation counter

Ports:
clock  input  1  rising-edge clock shared with the ULA
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  OP_W  opcode, same encoding as ULA Seletor
cmd_a  input  DATA_W  operand A
cmd_b  input  DATA_W  operand B
cmd_acc  input  1  use previous result as A (only with ULA_SEQ_ACC_EN)
alu_sel  output  OP_W  to ULA Seletor
alu_a  output  DATA_W  to ULA A
alu_b  output  DATA_W  to ULA B
alu_s  input  RES_W  from ULA S
res_valid  output  1  result present
res_ready  input  1  consumer accepts result
res_data  output  RES_W  captured result
res_zero  output  1  res_data == 0
res_err  output  1  divide by zero (op 4'b0011 with B == 0)
busy  output  1  state != IDLE
op_count  output  CNT_W  number of results handed off

Behaviour:
- Interface: one clock, `clock`; synchronous active-high `reset`.
- Reset values: state=IDLE; alu_sel/alu_a/alu_b=0; res_data=0; res_valid=0; res_zero=0; res_err=0; op_count=0.
- All outputs are registered, except cmd_ready = (state==IDLE) and busy = (state!=IDLE).
- States: IDLE, ISSUE, WAIT, DONE.
  - IDLE: when cmd_valid && cmd_ready, latch cmd_op/cmd_a/cmd_b into alu_sel/alu_a/alu_b and record div-by-zero = (cmd_op==4'b0011 && cmd_b==0); go to ISSUE.
  - ISSUE: ULA inputs are stable; the ULA samples them at the end of this cycle; go to WAIT.
  - WAIT: alu_s is valid; capture it into res_data, compute res_zero, set res_err, set res_valid; go to DONE.
  - DONE: hold res_* stable while res_valid && !res_ready. On res_ready: clear res_valid, op_count += 1 (wraps from 2^CNT_W-1 to 0), go to IDLE.
- Latency: accept edge to res_valid high = 3 clocks. Back-to-back throughput = 1 op per 4 clocks, with res_ready tied high.
- Divide by zero: res_data forced to 0, res_err=1, res_zero=1. The ULA output is ignored for that op.
- alu_sel/alu_a/alu_b hold their last values outside ISSUE/WAIT. No spurious changes while in DONE.
- cmd_valid while busy: ignored, no queuing. The command must be held by the source until cmd_ready.
- res_ready while res_valid=0: no effect.
- Reset mid-operation, any state: next state IDLE with reset values. The in-flight ULA output is discarded and op_count is not incremented.
- Reset and cmd_valid in the same cycle: the command is not accepted.
- Arithmetic: no arithmetic in this block except op_count; res_data is taken verbatim from alu_s.

Optional Feature:
ULA_SEQ_ACC_EN
- Defined: when cmd_acc=1 at accept, alu_a is loaded from res_data[DATA_W-1:0] of the last completed op (0 after reset) instead of cmd_a. This enables chained operations.
- Not defined: cmd_acc is ignored and alu_a always comes from cmd_a. The port remains present in both builds.

Decomposition:
- Shared package ula_pkg:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_SHL=4, OP_SHR=5, OP_ROL=6, OP_ROR=7, OP_AND=8, OP_OR=9, OP_XOR=10, OP_NOR=11, OP_NAND=12, OP_XNOR=13, OP_GT=14, OP_EQ=15
  - width constants DATA_W/RES_W/OP_W
  - sequencer state encoding
- No sub-module: a single FSM. The ULA is instantiated alongside in the parent, not inside this block.

Test Plan:
- ADD: op=0, A=200, B=100, res_ready=1 -> res_valid exactly 3 clocks after accept; res_data=300; res_zero=0; res_err=0; op_count=1.
- MUL then backpressure: op=2, A=255, B=255, res_ready=0 for 5 clocks -> res_data=65025 held stable; op_count stays 0 until res_ready, then becomes 1.
- DIV by zero: op=3, A=17, B=0 -> res_data=0, res_err=1, res_zero=1. Next op=3, A=17, B=5 -> res_data=3, res_err=0.
- Busy rejection and equality: while in ISSUE, drive a second command -> cmd_ready=0, command not taken. Hold it until IDLE -> op=15, A=B=9 yields res_data=1.
- Reset in WAIT: assert reset for 1 clock -> res_valid=0, op_count=0, state IDLE; a new op=1, A=5, B=7 -> res_data=16'hFFFE.
- ULA_SEQ_ACC_EN: op=0, A=3, B=4 -> 7; then cmd_acc=1, op=2, B=6 -> res_data=42. Without the macro, the same stimulus with cmd_a=0 -> 0.
